// File: rtl/simon_word_io.sv
// simon_word_io: word-serial I/O stage for the SIMON 128/128 core.
// Assembles W-bit upstream words into plaintext/key blocks, hands them to the
// core via newData/ldData and newKey/ldKey, captures the cipher on doneData
// and streams it back out as W-bit words, least-significant word first.
// Build option: define SIMON_WORD_IO_BYTESWAP_EN to byte-reverse every bus word
// on the way in and on the way out (big-endian bus); latency is unchanged.
module simon_word_io #(
    parameter int W = 32,
    parameter int N = 64,
    parameter int M = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_word,
    input  logic             in_sel,
    input  logic             in_encdec,
    output logic             newData,
    output logic             newKey,
    output logic             enc_dec,
    output logic [2*N-1:0]   plain,
    output logic [M*N-1:0]   key,
    input  logic             ldData,
    input  logic             ldKey,
    input  logic             doneData,
    output logic             readData,
    input  logic [2*N-1:0]   cipher,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_word
);

    localparam int DPB  = (2 * N) / W;
    localparam int KPB  = (M * N) / W;
    localparam int GMAX = (DPB > KPB) ? DPB : KPB;
    localparam int ABW  = GMAX * W;
    localparam int CW   = (GMAX > 1) ? $clog2(GMAX) : 1;
    localparam int OCW  = (DPB > 1) ? $clog2(DPB) : 1;

    typedef enum logic {
        OIDLE,
        OSEND
    } ostate_t;

    // Bus-word byte order adaptation, shared by the input and output paths.
    function automatic logic [W-1:0] bus_swap(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef SIMON_WORD_IO_BYTESWAP_EN
        r = '0;
        for (int unsigned b = 0; b < W / 8; b++) begin
            r[b*8 +: 8] = w[W-8-b*8 +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    // Assembly state
    logic [ABW-1:0] asm_buf;
    logic [CW-1:0]  asm_cnt;
    logic           asm_full;
    logic           asm_sel;
    logic           asm_enc;

    // Holding-register state
    logic           data_pend;
    logic           key_pend;

    // Output state
    ostate_t        ostate;
    logic [2*N-1:0] obuf;
    logic [2*N-1:0] obuf_shr;
    logic [OCW-1:0] ocnt;

    logic           accept;
    logic           grp_sel;
    logic [CW-1:0]  grp_last;
    logic [W-1:0]   word_sw;
    logic           xfer_data;
    logic           xfer_key;

    assign in_ready  = !asm_full;
    assign accept    = in_valid && !asm_full;
    // The group target comes straight from in_sel on the first word, then from the latch.
    assign grp_sel   = (asm_cnt == '0) ? in_sel : asm_sel;
    assign grp_last  = grp_sel ? CW'(KPB - 1) : CW'(DPB - 1);
    assign word_sw   = bus_swap(in_word);

    assign newKey    = key_pend;
    assign newData   = data_pend && !key_pend;

    // Transfer only into a free holding register; a same-edge ld* clear is seen
    // as still pending here, so the transfer naturally lands one edge later.
    assign xfer_data = asm_full && !asm_sel && !data_pend;
    assign xfer_key  = asm_full &&  asm_sel && !key_pend;

    assign obuf_shr  = obuf >> W;

    // Word assembler: collect one group LS word first, then hold until transferred.
    always_ff @(posedge clk) begin
        if (R) begin
            asm_buf  <= '0;
            asm_cnt  <= '0;
            asm_full <= 1'b0;
            asm_sel  <= 1'b0;
            asm_enc  <= 1'b0;
        end else if (xfer_data || xfer_key) begin
            asm_full <= 1'b0;
            asm_cnt  <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < GMAX; i++) begin
                if (asm_cnt == CW'(i)) begin
                    asm_buf[i*W +: W] <= word_sw;
                end
            end
            if (asm_cnt == '0) begin
                asm_sel <= in_sel;
                asm_enc <= in_encdec;
            end
            if (asm_cnt == grp_last) begin
                asm_full <= 1'b1;
                asm_cnt  <= '0;
            end else begin
                asm_cnt  <= asm_cnt + 1'b1;
            end
        end
    end

    // Holding registers toward the core and their pending flags.
    always_ff @(posedge clk) begin
        if (R) begin
            data_pend <= 1'b0;
            key_pend  <= 1'b0;
            plain     <= '0;
            key       <= '0;
            enc_dec   <= 1'b0;
        end else begin
            if (xfer_data) begin
                plain     <= asm_buf[2*N-1:0];
                enc_dec   <= asm_enc;
                data_pend <= 1'b1;
            end else if (ldData && newData) begin
                data_pend <= 1'b0;
            end

            if (xfer_key) begin
                key       <= asm_buf[M*N-1:0];
                key_pend  <= 1'b1;
            end else if (ldKey && key_pend) begin
                key_pend  <= 1'b0;
            end
        end
    end

    // Output FSM: capture the cipher, then stream it out word by word.
    always_ff @(posedge clk) begin
        if (R) begin
            ostate    <= OIDLE;
            obuf      <= '0;
            ocnt      <= '0;
            readData  <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
        end else begin
            readData <= 1'b0;
            case (ostate)
                OIDLE: begin
                    if (doneData) begin
                        obuf      <= cipher;
                        ocnt      <= '0;
                        readData  <= 1'b1;
                        out_valid <= 1'b1;
                        out_word  <= bus_swap(cipher[W-1:0]);
                        ostate    <= OSEND;
                    end
                end
                OSEND: begin
                    if (out_ready) begin
                        if (ocnt == OCW'(DPB - 1)) begin
                            out_valid <= 1'b0;
                            out_word  <= '0;
                            ostate    <= OIDLE;
                        end else begin
                            // obuf is kept shifted so word ocnt is always in its LS slot.
                            ocnt     <= ocnt + 1'b1;
                            obuf     <= obuf_shr;
                            out_word <= bus_swap(obuf_shr[W-1:0]);
                        end
                    end
                end
                default: ostate <= OIDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_word_io.sv
// tb_simon_word_io: directed bench for simon_word_io at default parameters.
// Expected values follow the build option SIMON_WORD_IO_BYTESWAP_EN.
module tb_simon_word_io;

    logic         clk = 1'b0;
    logic         R = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_word = '0;
    logic         in_sel = 1'b0;
    logic         in_encdec = 1'b0;
    logic         newData;
    logic         newKey;
    logic         enc_dec;
    logic [127:0] plain;
    logic [127:0] key;
    logic         ldData = 1'b0;
    logic         ldKey = 1'b0;
    logic         doneData = 1'b0;
    logic         readData;
    logic [127:0] cipher = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_word;

    int errors = 0;
    int checks = 0;

    simon_word_io #(.W(32), .N(64), .M(2)) dut (
        .clk(clk), .R(R),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_sel(in_sel), .in_encdec(in_encdec),
        .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
        .plain(plain), .key(key),
        .ldData(ldData), .ldKey(ldKey),
        .doneData(doneData), .readData(readData), .cipher(cipher),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sw32(input logic [31:0] w);
`ifdef SIMON_WORD_IO_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] sw128(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = sw32(b[i*32 +: 32]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [31:0] w, input logic s, input logic e);
        int n;
        in_valid = 1'b1; in_word = w; in_sel = s; in_encdec = e;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Later words carry inverted sel/encdec: only the first word may matter.
    task automatic send_group(input logic [127:0] blk, input logic s, input logic e);
        for (int i = 0; i < 4; i++) begin
            send_word(blk[i*32 +: 32], (i == 0) ? s : ~s, (i == 0) ? e : ~e);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        chk({tag, "_newData"},  {127'd0, newData}, 128'd0);
        chk({tag, "_newKey"},   {127'd0, newKey}, 128'd0);
        chk({tag, "_enc_dec"},  {127'd0, enc_dec}, 128'd0);
        chk({tag, "_plain"},    plain, 128'd0);
        chk({tag, "_key"},      key, 128'd0);
        chk({tag, "_readData"}, {127'd0, readData}, 128'd0);
        chk({tag, "_out_valid"},{127'd0, out_valid}, 128'd0);
        chk({tag, "_out_word"}, {96'd0, out_word}, 128'd0);
    endtask

    localparam logic [127:0] K1 = 128'h0C0D0E0F_08090A0B_04050607_00010203;
    localparam logic [127:0] K2 = 128'h10000003_10000002_10000001_10000000;
    localparam logic [127:0] D1 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [127:0] E1 = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    localparam logic [127:0] F1 = 128'hF0F00003_F0F00002_F0F00001_F0F00000;
    localparam logic [127:0] C1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] C2 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] C3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    logic [127:0] cw;

    initial begin
        // Reset
        tick();
        tick();
        R = 1'b0;
        chk_reset("rst");

        // Single key group
        send_group(K1, 1'b1, 1'b0);
        chk("k1_full_in_ready", {127'd0, in_ready}, 128'd0);
        chk("k1_newKey_early", {127'd0, newKey}, 128'd0);
        tick();
        chk("k1_newKey", {127'd0, newKey}, 128'd1);
        chk("k1_key", key, sw128(K1));
        chk("k1_newData", {127'd0, newData}, 128'd0);
        chk("k1_in_ready", {127'd0, in_ready}, 128'd1);
        ldKey = 1'b1;
        tick();
        ldKey = 1'b0;
        chk("k1_newKey_clr", {127'd0, newKey}, 128'd0);

        // Key, data, data back-to-back with ldKey withheld
        send_group(K2, 1'b1, 1'b0);
        send_group(D1, 1'b0, 1'b1);
        send_group(E1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("wh_newData", {127'd0, newData}, 128'd0);
            chk("wh_newKey", {127'd0, newKey}, 128'd1);
            chk("wh_in_ready", {127'd0, in_ready}, 128'd0);
            ldData = (i == 4);
            tick();
            ldData = 1'b0;
        end
        chk("wh_key", key, sw128(K2));
        chk("wh_plain_held", plain, sw128(D1));
        ldKey = 1'b1;
        tick();
        ldKey = 1'b0;
        chk("d1_newKey", {127'd0, newKey}, 128'd0);
        chk("d1_newData", {127'd0, newData}, 128'd1);
        chk("d1_plain", plain, sw128(D1));
        chk("d1_enc_dec", {127'd0, enc_dec}, 128'd1);
        chk("d1_in_ready", {127'd0, in_ready}, 128'd0);
        ldData = 1'b1;
        tick();
        ldData = 1'b0;
        chk("d1_newData_clr", {127'd0, newData}, 128'd0);
        chk("e1_clear_first", {127'd0, in_ready}, 128'd0);
        tick();
        chk("e1_newData", {127'd0, newData}, 128'd1);
        chk("e1_plain", plain, sw128(E1));
        chk("e1_enc_dec", {127'd0, enc_dec}, 128'd0);
        chk("e1_in_ready", {127'd0, in_ready}, 128'd1);
        ldData = 1'b1;
        tick();
        ldData = 1'b0;
        chk("e1_newData_clr", {127'd0, newData}, 128'd0);

        // Cipher out with out_ready held high
        cipher = C1; doneData = 1'b1; out_ready = 1'b1;
        tick();
        doneData = 1'b0;
        chk("c1_readData", {127'd0, readData}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            cw = C1 >> (i * 32);
            chk("c1_out_valid", {127'd0, out_valid}, 128'd1);
            chk("c1_out_word", {96'd0, out_word}, {96'd0, sw32(cw[31:0])});
            tick();
            chk("c1_readData_low", {127'd0, readData}, 128'd0);
        end
        chk("c1_out_valid_end", {127'd0, out_valid}, 128'd0);

        // out_ready toggling while doneData stays asserted
        cipher = C2; doneData = 1'b1; out_ready = 1'b0;
        tick();
        cipher = C3;
        chk("c2_readData", {127'd0, readData}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            cw = C2 >> (i * 32);
            out_ready = 1'b0;
            chk("c2_word_a", {96'd0, out_word}, {96'd0, sw32(cw[31:0])});
            tick();
            chk("c2_word_b", {96'd0, out_word}, {96'd0, sw32(cw[31:0])});
            chk("c2_valid", {127'd0, out_valid}, 128'd1);
            chk("c2_readData_low", {127'd0, readData}, 128'd0);
            out_ready = 1'b1;
            tick();
        end
        chk("c2_idle_valid", {127'd0, out_valid}, 128'd0);
        chk("c2_idle_readData", {127'd0, readData}, 128'd0);
        tick();
        doneData = 1'b0;
        chk("c3_readData", {127'd0, readData}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            cw = C3 >> (i * 32);
            chk("c3_valid", {127'd0, out_valid}, 128'd1);
            chk("c3_word", {96'd0, out_word}, {96'd0, sw32(cw[31:0])});
            tick();
        end
        chk("c3_valid_end", {127'd0, out_valid}, 128'd0);

        // Reset with a pending key, a partial data group and a cipher in flight
        send_group(K1, 1'b1, 1'b0);
        tick();
        chk("r_key_pending", {127'd0, newKey}, 128'd1);
        send_word(32'h12340000, 1'b0, 1'b1);
        send_word(32'h12340001, 1'b1, 1'b0);
        cipher = C1; doneData = 1'b1; out_ready = 1'b0;
        tick();
        doneData = 1'b0;
        chk("r_osend", {127'd0, out_valid}, 128'd1);
        R = 1'b1;
        tick();
        R = 1'b0;
        chk_reset("r2");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r2_no_out", {127'd0, out_valid}, 128'd0);
        end
        send_group(F1, 1'b0, 1'b1);
        chk("f1_newData_early", {127'd0, newData}, 128'd0);
        tick();
        chk("f1_newData", {127'd0, newData}, 128'd1);
        chk("f1_plain", plain, sw128(F1));
        chk("f1_enc_dec", {127'd0, enc_dec}, 128'd1);
        chk("f1_newKey", {127'd0, newKey}, 128'd0);
        ldData = 1'b1;
        tick();
        ldData = 1'b0;
        chk("f1_newData_clr", {127'd0, newData}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
